// File: rtl/aes_mixcol_engine_if.sv
// Valid/ready bundle for the AES MixColumns engine.
// Master drives states in and takes results out.
interface aes_mixcol_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [127:0] datain;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dataout;

  modport master (
    output in_valid, mode, datain, out_ready,
    input  in_ready, out_valid, dataout
  );

  modport slave (
    input  in_valid, mode, datain, out_ready,
    output in_ready, out_valid, dataout
  );
endinterface

// File: rtl/aes_mixcol_engine.sv
// Iterative AES MixColumns / InvMixColumns / bypass engine.
// Mixes COLS_PER_CYCLE columns per cycle while rotating the state.
module aes_mixcol_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_mixcol_engine_if.slave   io,
  output logic                 busy
);

  localparam int N = COLS_PER_CYCLE;
  localparam int W = 32 * N;
  localparam logic [1:0] LAST = 2'(4 / N - 1);

  if (!(N == 1 || N == 2 || N == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [1:0]   md_q, md_d;
  logic [1:0]   cnt_q, cnt_d;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix(
    input logic [31:0] c,
    input logic        inv
  );
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] p [4];
    logic [7:0] q [4];
    logic [7:0] s [4];
    logic [7:0] t [4];
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31-8*k -: 8];
      x2[k] = xt(a[k]);
      x4[k] = xt(x2[k]);
      x8[k] = xt(x4[k]);
      // p:02 q:03 s:0e t:0b, with 0d/09 built inline
      p[k]  = x2[k];
      q[k]  = x2[k] ^ a[k];
      s[k]  = x8[k] ^ x4[k] ^ x2[k];
      t[k]  = x8[k] ^ x2[k] ^ a[k];
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (inv)
        r[31-8*i -: 8] = s[i] ^ t[(i+1)%4]
                       ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                       ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      else
        r[31-8*i -: 8] = p[i] ^ q[(i+1)%4]
                       ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
    return r;
  endfunction

  logic [W-1:0]   top;
  logic [W-1:0]   mixed;
  logic [127:0]   rot;

  assign top = st_q[127 -: W];

  for (genvar g = 0; g < N; g++) begin : g_col
    assign mixed[W-1-32*g -: 32] = md_q[1]
      ? top[W-1-32*g -: 32]
      : mix(top[W-1-32*g -: 32], md_q[0]);
  end

  if (N == 4) begin : g_rot_all
    assign rot = mixed;
  end else begin : g_rot_part
    assign rot = {st_q[127-W:0], mixed};
  end

  assign io.in_ready  = (state_q == IDLE)
                      | ((state_q == DONE) & io.out_ready);
  assign io.out_valid = (state_q == DONE);
  assign io.dataout   = st_q;
  assign busy         = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    md_d    = md_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          st_d    = io.datain;
          md_d    = io.mode;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        st_d  = rot;
        cnt_d = 2'(cnt_q + 2'd1);
        if (cnt_q == LAST)
          state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) begin
          if (io.in_valid) begin
            st_d    = io.datain;
            md_d    = io.mode;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      md_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      md_q    <= md_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_aes_mixcol_engine.sv
// Bench for aes_mixcol_engine at 1, 2 and 4 columns per cycle.
// Results are checked against a GF(2^8) reference model.
module tb_aes_mixcol_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]   iv;
  logic [2:0]   ordy;
  logic [1:0]   mi [3];
  logic [127:0] di [3];
  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [2:0]   bsy;
  logic [127:0] dq [3];

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_mixcol_engine_if bus ();
    assign bus.in_valid  = iv[g];
    assign bus.mode      = mi[g];
    assign bus.datain    = di[g];
    assign bus.out_ready = ordy[g];
    assign ir[g]         = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign dq[g]         = bus.dataout;
    aes_mixcol_engine #(.COLS_PER_CYCLE(1 << g)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus.slave),
      .busy  (bsy[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [8:0] t;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      t = {a, 1'b0};
      a = t[8] ? (t[7:0] ^ 8'h1b) : t[7:0];
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic [1:0] m);
    logic [7:0] fwd [4];
    logic [7:0] inv [4];
    logic [7:0] acc;
    logic [127:0] r;
    fwd = '{8'h02, 8'h03, 8'h01, 8'h01};
    inv = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    if (m[1]) return s;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(m[0] ? inv[(k - rw + 4) % 4] : fwd[(k - rw + 4) % 4],
                      s[127 - 32*c - 8*k -: 8]);
        r[127 - 32*c - 8*rw -: 8] = acc;
      end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept one state on engine d, wait for the result, then drain it.
  task automatic run(input int d, input logic [127:0] data, input logic [1:0] m,
                     input logic [127:0] exp, input string tag);
    int lat;
    chk({tag, "_rdy"}, 128'(ir[d]), 128'd1);
    iv[d] = 1'b1;
    di[d] = data;
    mi[d] = m;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    di[d] = junk();
    mi[d] = ~m;
    chk({tag, "_busy"}, 128'(bsy[d]), 128'd1);
    lat = 0;
    while (!ov[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'(4 >> d));
    chk({tag, "_data"}, dq[d], exp);
    chk({tag, "_nordy"}, 128'(ir[d]), 128'd0);
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    chk({tag, "_idle"}, 128'(ov[d]), 128'd0);
  endtask

  localparam logic [127:0] FA = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FB = 128'h046681e5e0cb199a48f8d37a2806264c;

  initial begin
    logic [127:0] a, b, hold;
    logic [1:0]   m;
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '0;
    for (int i = 0; i < 3; i++) begin
      mi[i] = '0;
      di[i] = '0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_rdy%0d", d), 128'(ir[d]), 128'd1);
      chk($sformatf("rst_ov%0d", d), 128'(ov[d]), 128'd0);
      chk($sformatf("rst_busy%0d", d), 128'(bsy[d]), 128'd0);
      chk($sformatf("rst_dout%0d", d), dq[d], 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 3; d++) begin
      run(d, FA, 2'b00, FB, $sformatf("fips_fwd%0d", d));
      run(d, FB, 2'b01, FA, $sformatf("fips_inv%0d", d));
      run(d, {4{32'hdb135345}}, 2'b00, {4{32'h8e4da1bc}}, $sformatf("col1_fwd%0d", d));
      run(d, {4{32'h8e4da1bc}}, 2'b01, {4{32'hdb135345}}, $sformatf("col1_inv%0d", d));
      run(d, {4{32'hf20a225c}}, 2'b00, {4{32'h9fdc589d}}, $sformatf("col2_fwd%0d", d));
      run(d, {4{32'h9fdc589d}}, 2'b01, {4{32'hf20a225c}}, $sformatf("col2_inv%0d", d));
      run(d, {16{8'hc6}}, 2'b00, {16{8'hc6}}, $sformatf("fix_c6f%0d", d));
      run(d, {16{8'hc6}}, 2'b01, {16{8'hc6}}, $sformatf("fix_c6i%0d", d));
      run(d, {16{8'h01}}, 2'b00, {16{8'h01}}, $sformatf("fix_01f%0d", d));
      run(d, {16{8'h01}}, 2'b01, {16{8'h01}}, $sformatf("fix_01i%0d", d));
      a = junk();
      run(d, a, 2'b10, a, $sformatf("byp10_%0d", d));
      a = junk();
      run(d, a, 2'b11, a, $sformatf("byp11_%0d", d));
      for (int n = 0; n < 8; n++) begin
        a = junk();
        m = 2'($urandom_range(0, 3));
        run(d, a, m, ref_mix(a, m), $sformatf("rnd%0d_%0d", d, n));
      end
    end

    // back-pressure then back-to-back accept on the single-column engine
    a = junk();
    b = junk();
    iv[0] = 1'b1;
    di[0] = a;
    mi[0] = 2'b00;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    di[0] = junk();
    mi[0] = 2'b01;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_valid", 128'(ov[0]), 128'd1);
    hold = dq[0];
    chk("bp_data", hold, ref_mix(a, 2'b00));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", i), dq[0], hold);
      chk($sformatf("bp_ov%0d", i), 128'(ov[0]), 128'd1);
      chk($sformatf("bp_rdy%0d", i), 128'(ir[0]), 128'd0);
    end
    ordy[0] = 1'b1;
    iv[0]   = 1'b1;
    di[0]   = b;
    mi[0]   = 2'b01;
    #1;
    chk("b2b_rdy", 128'(ir[0]), 128'd1);
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    iv[0]   = 1'b0;
    di[0]   = junk();
    mi[0]   = 2'b10;
    chk("b2b_busy", 128'(bsy[0]), 128'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_ov", 128'(ov[0]), 128'd1);
    chk("b2b_data", dq[0], ref_mix(b, 2'b01));
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;

    // asynchronous reset two cycles into BUSY
    a = junk();
    iv[0] = 1'b1;
    di[0] = a;
    mi[0] = 2'b00;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_rdy", 128'(ir[0]), 128'd1);
    chk("mrst_ov", 128'(ov[0]), 128'd0);
    chk("mrst_busy", 128'(bsy[0]), 128'd0);
    chk("mrst_dout", dq[0], 128'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mrst_noov%0d", i), 128'(ov[0]), 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_noov", 128'(ov[0]), 128'd0);
    run(0, FA, 2'b00, FB, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
